// File: rtl/uart_param_if.sv
// Host-side bus of the UART: baud divisor, TX write port, RX read port and
// the sticky error flags. Serial pins, clock and reset stay on the module.
interface uart_param_if #(parameter int DBIT = 8);
    logic [10:0]     timer_final_value;
    logic [DBIT-1:0] w_data;
    logic            wr_uart;
    logic            tx_full;
    logic            rd_uart;
    logic            rx_empty;
    logic [DBIT-1:0] r_data;
    logic            parity_err;
    logic            frame_err;
    logic            overrun_err;
    logic            clr_err;

    modport master (
        output timer_final_value, w_data, wr_uart, rd_uart, clr_err,
        input  tx_full, rx_empty, r_data, parity_err, frame_err, overrun_err
    );

    modport slave (
        input  timer_final_value, w_data, wr_uart, rd_uart, clr_err,
        output tx_full, rx_empty, r_data, parity_err, frame_err, overrun_err
    );
endinterface

// File: rtl/uart_param.sv
// Parameterised UART: tick generator, 2-flop rx synchroniser, RX/TX framing
// FSMs (optional parity, 1 or 2 stop bits) and a small FWFT FIFO per direction.

module uart_param_fifo #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem [0:2**AW-1];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         push_ok;
    logic         pop_ok;

    // The extra pointer MSB separates all-full from all-empty.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

    // Pointer update; pointers wrap naturally modulo 2^(AW+1).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
        end
    end

    // Storage array, no reset needed since dout is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= din;
    end
endmodule

module uart_param #(
    parameter int DBIT    = 8,
    parameter int PARITY  = 0,
    parameter int SB_TICK = 16,
    parameter int FIFO_W  = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    uart_param_if.slave  bus,
    output logic         tx,
    input  logic         rx
);
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_t;

    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DBIT - 1);

    // Parity bit that makes data XOR parity equal 1 (odd) or 0 (even).
    function automatic logic parity_of(input logic [DBIT-1:0] d);
        parity_of = (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    logic [10:0] tick_cnt;
    logic [10:0] tick_lim;
    logic        tick;
    logic        rx_meta;
    logic        rx_sync;

    assign tick = (tick_cnt == tick_lim);

    // Oversample tick; the divisor is captured at each wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
            tick_lim <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
            tick_lim <= bus.timer_final_value;
        end else begin
            tick_cnt <= tick_cnt + 11'd1;
        end
    end

    // Two-flop synchroniser on the asynchronous serial input, idling high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    uart_state_t     rx_state, rx_state_n;
    logic [4:0]      rx_s, rx_s_n;
    logic [2:0]      rx_n, rx_n_n;
    logic [DBIT-1:0] rx_b, rx_b_n;
    logic            rx_p, rx_p_n;
    logic            rx_done;
    logic            rx_full;

    // RX control state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state <= ST_IDLE;
            rx_s     <= '0;
            rx_n     <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_s     <= rx_s_n;
            rx_n     <= rx_n_n;
        end
    end

    // RX shift register and received parity bit.
    always_ff @(posedge clk) begin
        rx_b <= rx_b_n;
        rx_p <= rx_p_n;
    end

    // RX next state: mid-bit sampling from the centre of the start bit.
    always_comb begin
        rx_state_n = rx_state;
        rx_s_n     = rx_s;
        rx_n_n     = rx_n;
        rx_b_n     = rx_b;
        rx_p_n     = rx_p;
        rx_done    = 1'b0;
        case (rx_state)
            ST_IDLE: begin
                if (!rx_sync) begin
                    rx_state_n = ST_START;
                    rx_s_n     = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rx_s == 5'd7) begin
                        rx_s_n     = '0;
                        rx_n_n     = '0;
                        rx_state_n = rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_s_n = rx_s + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (rx_s == 5'd15) begin
                        rx_s_n = '0;
                        rx_b_n = {rx_sync, rx_b[DBIT-1:1]};
                        if (rx_n == BIT_LAST) rx_state_n = (PARITY != 0) ? ST_PARITY : ST_STOP;
                        else                  rx_n_n     = rx_n + 3'd1;
                    end else begin
                        rx_s_n = rx_s + 5'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    if (rx_s == 5'd15) begin
                        rx_s_n     = '0;
                        rx_p_n     = rx_sync;
                        rx_state_n = ST_STOP;
                    end else begin
                        rx_s_n = rx_s + 5'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (rx_s == STOP_LAST) begin
                        rx_done    = 1'b1;
                        rx_state_n = ST_IDLE;
                    end else begin
                        rx_s_n = rx_s + 5'd1;
                    end
                end
            end
            default: rx_state_n = ST_IDLE;
        endcase
    end

    logic par_err_q, frm_err_q, ovr_err_q;
    logic par_evt, frm_evt, ovr_evt;

    assign par_evt = rx_done && (PARITY != 0) && (rx_p != parity_of(rx_b));
    assign frm_evt = rx_done && !rx_sync;
    assign ovr_evt = rx_done && rx_full;

    // Sticky error flags; a new event beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
        end else begin
            par_err_q <= (par_err_q && !bus.clr_err) || par_evt;
            frm_err_q <= (frm_err_q && !bus.clr_err) || frm_evt;
            ovr_err_q <= (ovr_err_q && !bus.clr_err) || ovr_evt;
        end
    end

    assign bus.parity_err  = par_err_q;
    assign bus.frame_err   = frm_err_q;
    assign bus.overrun_err = ovr_err_q;

    uart_param_fifo #(.W(DBIT), .AW(FIFO_W)) rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rx_done),
        .pop     (bus.rd_uart),
        .din     (rx_b),
        .dout    (bus.r_data),
        .full    (rx_full),
        .empty   (bus.rx_empty)
    );

    uart_state_t     tx_state, tx_state_n;
    logic [4:0]      tx_s, tx_s_n;
    logic [2:0]      tx_n, tx_n_n;
    logic [DBIT-1:0] tx_b, tx_b_n;
    logic            tx_p, tx_p_n;
    logic            tx_pop;
    logic            tx_empty;
    logic [DBIT-1:0] tx_head;

    uart_param_fifo #(.W(DBIT), .AW(FIFO_W)) tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (bus.wr_uart),
        .pop     (tx_pop),
        .din     (bus.w_data),
        .dout    (tx_head),
        .full    (bus.tx_full),
        .empty   (tx_empty)
    );

    // TX control state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= ST_IDLE;
            tx_s     <= '0;
            tx_n     <= '0;
        end else begin
            tx_state <= tx_state_n;
            tx_s     <= tx_s_n;
            tx_n     <= tx_n_n;
        end
    end

    // TX shift register and outgoing parity bit.
    always_ff @(posedge clk) begin
        tx_b <= tx_b_n;
        tx_p <= tx_p_n;
    end

    // TX next state; the last stop tick chains straight into the next start bit.
    always_comb begin
        tx_state_n = tx_state;
        tx_s_n     = tx_s;
        tx_n_n     = tx_n;
        tx_b_n     = tx_b;
        tx_p_n     = tx_p;
        tx_pop     = 1'b0;
        case (tx_state)
            ST_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_b_n     = tx_head;
                    tx_p_n     = parity_of(tx_head);
                    tx_s_n     = '0;
                    tx_state_n = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (tx_s == 5'd15) begin
                        tx_s_n     = '0;
                        tx_n_n     = '0;
                        tx_state_n = ST_DATA;
                    end else begin
                        tx_s_n = tx_s + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (tx_s == 5'd15) begin
                        tx_s_n = '0;
                        tx_b_n = {1'b0, tx_b[DBIT-1:1]};
                        if (tx_n == BIT_LAST) tx_state_n = (PARITY != 0) ? ST_PARITY : ST_STOP;
                        else                  tx_n_n     = tx_n + 3'd1;
                    end else begin
                        tx_s_n = tx_s + 5'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    if (tx_s == 5'd15) begin
                        tx_s_n     = '0;
                        tx_state_n = ST_STOP;
                    end else begin
                        tx_s_n = tx_s + 5'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (tx_s == STOP_LAST) begin
                        tx_s_n = '0;
                        if (!tx_empty) begin
                            tx_pop     = 1'b1;
                            tx_b_n     = tx_head;
                            tx_p_n     = parity_of(tx_head);
                            tx_state_n = ST_START;
                        end else begin
                            tx_state_n = ST_IDLE;
                        end
                    end else begin
                        tx_s_n = tx_s + 5'd1;
                    end
                end
            end
            default: tx_state_n = ST_IDLE;
        endcase
    end

    // Serial line level decoded from the TX state; reset forces it high at once.
    always_comb begin
        tx = 1'b1;
        case (tx_state)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = tx_b[0];
            ST_PARITY: tx = tx_p;
            default:   tx = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_param.sv
// Bench for uart_param: a no-parity loopback instance and an even-parity
// instance whose rx can be driven directly from the bench.
module tb_uart_param;
    localparam int BITC = 80;          // clocks per bit with divisor 4
    localparam int BIT53 = 16 * 54;    // clocks per bit with divisor 53

    logic clk = 1'b0;
    logic reset_n;
    logic tx_a, tx_b, rx_b_line, drv_line;
    bit   drive_b;
    int   passes = 0;
    int   fails = 0;
    int   total = 0;

    always #5 clk = ~clk;

    uart_param_if #(.DBIT(8)) ifa ();
    uart_param_if #(.DBIT(8)) ifb ();

    assign rx_b_line = drive_b ? drv_line : tx_b;

    uart_param #(.DBIT(8), .PARITY(0), .SB_TICK(16), .FIFO_W(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa), .tx(tx_a), .rx(tx_a));
    uart_param #(.DBIT(8), .PARITY(2), .SB_TICK(16), .FIFO_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb), .tx(tx_b), .rx(rx_b_line));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference framing: start 0, data LSB first, optional parity, stop 1.
    function automatic logic ref_parity(input logic [7:0] d, input int mode);
        int ones;
        ones = $countones(d);
        if (mode == 1) return ((ones % 2) == 0);
        return ((ones % 2) == 1);
    endfunction

    function automatic logic [31:0] make_frame(input logic [7:0] d, input int mode,
                                               input bit bad_par, input bit bad_stop);
        logic [31:0] f;
        int k;
        f = '0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        k = 9;
        if (mode != 0) begin
            f[9] = ref_parity(d, mode) ^ bad_par;
            k = 10;
        end
        f[k] = ~bad_stop;
        return f;
    endfunction

    task automatic write_word(input int which, input logic [7:0] d);
        @(negedge clk);
        if (which == 0) begin ifa.w_data = d; ifa.wr_uart = 1'b1; end
        else            begin ifb.w_data = d; ifb.wr_uart = 1'b1; end
        @(negedge clk);
        ifa.wr_uart = 1'b0;
        ifb.wr_uart = 1'b0;
    endtask

    task automatic pop_word(input int which);
        @(negedge clk);
        if (which == 0) ifa.rd_uart = 1'b1; else ifb.rd_uart = 1'b1;
        @(negedge clk);
        ifa.rd_uart = 1'b0;
        ifb.rd_uart = 1'b0;
    endtask

    task automatic clear_errors(input int which);
        @(negedge clk);
        if (which == 0) ifa.clr_err = 1'b1; else ifb.clr_err = 1'b1;
        @(negedge clk);
        ifa.clr_err = 1'b0;
        ifb.clr_err = 1'b0;
    endtask

    task automatic wait_rx(input int which, input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = (which == 0) ? !ifa.rx_empty : !ifb.rx_empty;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_tx_low(input int which, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = ((which == 0) ? tx_a : tx_b) == 1'b0;
        end
    endtask

    // Samples the serial output at the centre of each bit of one frame.
    task automatic capture_tx(input int which, input int n, input int budget,
                              output logic [31:0] f);
        bit seen;
        f = '1;
        wait_tx_low(which, budget, seen);
        if (seen) begin
            f = '0;
            repeat (BITC / 2) @(negedge clk);
            f[0] = (which == 0) ? tx_a : tx_b;
            for (int i = 1; i < n; i++) begin
                repeat (BITC) @(negedge clk);
                f[i] = (which == 0) ? tx_a : tx_b;
            end
        end
    endtask

    // Drives one frame on dut_b's rx; a short stop bit avoids a trailing false start.
    task automatic drive_frame(input logic [31:0] f, input int n, input bit short_stop);
        int cyc;
        for (int i = 0; i < n; i++) begin
            drv_line = f[i];
            cyc = (i == n - 1 && short_stop) ? (BITC * 3) / 4 : BITC;
            repeat (cyc) @(negedge clk);
        end
        drv_line = 1'b1;
    endtask

    initial begin
        logic [7:0]  d;
        logic [7:0]  words [5];
        logic [7:0]  exp_q [$];
        logic [31:0] f;
        bit          exp_ovr;
        bit          seen;

        reset_n = 1'b0;
        drive_b = 1'b0;
        drv_line = 1'b1;
        ifa.timer_final_value = 11'd53; ifb.timer_final_value = 11'd4;
        ifa.w_data = '0; ifa.wr_uart = 1'b0; ifa.rd_uart = 1'b0; ifa.clr_err = 1'b0;
        ifb.w_data = '0; ifb.wr_uart = 1'b0; ifb.rd_uart = 1'b0; ifb.clr_err = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_a_tx", 32'(tx_a), 32'd1);
        check("rst_a_tx_full", 32'(ifa.tx_full), 32'd0);
        check("rst_a_rx_empty", 32'(ifa.rx_empty), 32'd1);
        check("rst_a_r_data", 32'(ifa.r_data), 32'd0);
        check("rst_a_errs", {29'd0, ifa.parity_err, ifa.frame_err, ifa.overrun_err}, 32'd0);
        check("rst_b_tx", 32'(tx_b), 32'd1);
        check("rst_b_rx_empty", 32'(ifb.rx_empty), 32'd1);
        check("rst_b_errs", {29'd0, ifb.parity_err, ifb.frame_err, ifb.overrun_err}, 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Loopback at divisor 53, no parity.
        write_word(0, 8'h7E);
        wait_rx(0, BIT53 * 14, "lb53_wait");
        check("lb53_r_data", 32'(ifa.r_data), 32'h7E);
        check("lb53_errs", {29'd0, ifa.parity_err, ifa.frame_err, ifa.overrun_err}, 32'd0);
        pop_word(0);
        check("lb53_empty_after_pop", 32'(ifa.rx_empty), 32'd1);
        check("lb53_r_data_zero", 32'(ifa.r_data), 32'd0);

        ifa.timer_final_value = 11'd4;
        repeat (200) @(negedge clk);

        // Five random words: TX FIFO fills, RX FIFO overruns on the fifth.
        for (int i = 0; i < 5; i++) words[i] = 8'($urandom_range(0, 255));
        exp_q = {};
        exp_ovr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (exp_q.size() < 4) exp_q.push_back(words[i]);
            else exp_ovr = 1'b1;
        end
        write_word(0, words[0]);
        repeat (5) @(negedge clk);
        for (int i = 1; i < 5; i++) begin
            write_word(0, words[i]);
            if (i == 3) check("fifo_tx_full_at3", 32'(ifa.tx_full), 32'd0);
        end
        check("fifo_tx_full_at4", 32'(ifa.tx_full), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < BITC * 10 * 7 && !seen; i++) begin
            @(negedge clk);
            seen = ifa.overrun_err;
        end
        check("fifo_overrun", 32'(seen), 32'(exp_ovr));
        check("fifo_other_errs", {30'd0, ifa.parity_err, ifa.frame_err}, 32'd0);
        while (exp_q.size() > 0) begin
            d = exp_q.pop_front();
            check("fifo_order", 32'(ifa.r_data), 32'(d));
            pop_word(0);
        end
        check("fifo_drained", 32'(ifa.rx_empty), 32'd1);
        clear_errors(0);
        check("fifo_overrun_clr", 32'(ifa.overrun_err), 32'd0);

        // Even parity: serial format of 8'hA5 and loopback.
        write_word(1, 8'hA5);
        capture_tx(1, 11, 2000, f);
        check("par_tx_frame", f, make_frame(8'hA5, 2, 1'b0, 1'b0));
        wait_rx(1, 2000, "par_lb_wait");
        check("par_lb_r_data", 32'(ifb.r_data), 32'hA5);
        check("par_lb_errs", {30'd0, ifb.parity_err, ifb.frame_err}, 32'd0);
        pop_word(1);

        // Driven frame with inverted parity bit.
        drive_b = 1'b1;
        repeat (20) @(negedge clk);
        d = 8'($urandom_range(0, 255));
        drive_frame(make_frame(d, 2, 1'b1, 1'b0), 11, 1'b0);
        wait_rx(1, 500, "badpar_wait");
        check("badpar_r_data", 32'(ifb.r_data), 32'(d));
        check("badpar_flag", 32'(ifb.parity_err), 32'd1);
        repeat (300) @(negedge clk);
        check("badpar_sticky", 32'(ifb.parity_err), 32'd1);
        pop_word(1);
        clear_errors(1);
        check("badpar_clr", 32'(ifb.parity_err), 32'd0);

        // Driven frame with correct parity.
        d = 8'($urandom_range(0, 255));
        drive_frame(make_frame(d, 2, 1'b0, 1'b0), 11, 1'b0);
        wait_rx(1, 500, "goodpar_wait");
        check("goodpar_r_data", 32'(ifb.r_data), 32'(d));
        check("goodpar_errs", {30'd0, ifb.parity_err, ifb.frame_err}, 32'd0);
        pop_word(1);

        // Driven frame with stop bit 0.
        d = 8'($urandom_range(0, 255));
        drive_frame(make_frame(d, 2, 1'b0, 1'b1), 11, 1'b1);
        wait_rx(1, 500, "frm_wait");
        check("frm_r_data", 32'(ifb.r_data), 32'(d));
        check("frm_flag", 32'(ifb.frame_err), 32'd1);
        check("frm_no_par", 32'(ifb.parity_err), 32'd0);
        pop_word(1);
        clear_errors(1);
        check("frm_clr", 32'(ifb.frame_err), 32'd0);
        repeat (200) @(negedge clk);
        check("frm_no_extra_word", 32'(ifb.rx_empty), 32'd1);

        // Glitch of four ticks on rx is rejected.
        drv_line = 1'b0;
        repeat (20) @(negedge clk);
        drv_line = 1'b1;
        repeat (400) @(negedge clk);
        check("glitch_empty", 32'(ifb.rx_empty), 32'd1);
        check("glitch_errs", {29'd0, ifb.parity_err, ifb.frame_err, ifb.overrun_err}, 32'd0);

        // Reset in the middle of a TX data bit, then a fresh frame.
        write_word(0, 8'h0F);
        wait_tx_low(0, 2000, seen);
        check("rst_mid_started", 32'(seen), 32'd1);
        repeat (BITC * 2 + BITC / 2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("rst_mid_tx_high", 32'(tx_a), 32'd1);
        check("rst_mid_rx_empty", 32'(ifa.rx_empty), 32'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        d = 8'($urandom_range(0, 255));
        write_word(0, d);
        capture_tx(0, 10, 2000, f);
        check("rst_fresh_frame", f, make_frame(d, 0, 1'b0, 1'b0));
        wait_rx(0, 2000, "rst_fresh_wait");
        check("rst_fresh_r_data", 32'(ifa.r_data), 32'(d));
        check("rst_fresh_errs", {29'd0, ifa.parity_err, ifa.frame_err, ifa.overrun_err}, 32'd0);
        pop_word(0);
        check("rst_fresh_single", 32'(ifa.rx_empty), 32'd1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, total);
        $fatal(1, "watchdog");
    end
endmodule
